// File: rtl/ex_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_stage_pkg                                                         |
// | ALU/RV opcode constants and defaults shared by decode and execute.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ex_stage_pkg;

   localparam int D_WIDTH_DEF = 32;
   localparam int N_REGS_DEF  = 32;
   localparam int RF_SIZE_DEF = $clog2(N_REGS_DEF);
   localparam int OP_SIZE_DEF = 4;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_INV = 4'b1111;

   localparam logic [6:0] RV_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] RV_OP_STORE  = 7'b0100011;
   localparam logic [6:0] RV_OP_IMM    = 7'b0010011;
   localparam logic [6:0] RV_OP_REG    = 7'b0110011;

   typedef struct packed {
      logic reg_write;
      logic mem_we;
      logic mem_re;
      logic mem_to_reg;
   } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ex_stage_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_stage_alu                                                         |
// | Combinational integer ALU; unsupported opcodes flag illegal.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_stage_alu
   import ex_stage_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF,
   parameter int OP_SIZE = OP_SIZE_DEF
) (
   input  logic [D_WIDTH-1:0] a,
   input  logic [D_WIDTH-1:0] b,
   input  logic [OP_SIZE-1:0] op,
   output logic [D_WIDTH-1:0] result,
   output logic               illegal
);

   logic w_lt;
   assign w_lt = ($signed(a) < $signed(b));

   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         OP_SIZE'(ALU_ADD): result = a + b;
         OP_SIZE'(ALU_SUB): result = a - b;
         OP_SIZE'(ALU_AND): result = a & b;
         OP_SIZE'(ALU_OR):  result = a | b;
         OP_SIZE'(ALU_XOR): result = a ^ b;
         OP_SIZE'(ALU_SLT): result = {{(D_WIDTH-1){1'b0}}, w_lt};
         default:           illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_stage                                                             |
// | Execute stage: operand forwarding, ALU and EX/MEM pipeline register. |
// | Forwarding paths present only when EX_FWD_EN is defined.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF,
   parameter int N_REGS  = N_REGS_DEF,
   parameter int RF_SIZE = $clog2(N_REGS),
   parameter int OP_SIZE = OP_SIZE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               flush,
   input  logic [RF_SIZE-1:0] rs1_ex,
   input  logic [RF_SIZE-1:0] rs2_ex,
   input  logic [D_WIDTH-1:0] rs1_val_ex,
   input  logic [D_WIDTH-1:0] rs2_val_ex,
   input  logic [D_WIDTH-1:0] imm_ex,
   input  logic [RF_SIZE-1:0] rd_ex,
   input  logic               reg_write_ex,
   input  logic               alu_src_imm_ex,
   input  logic [OP_SIZE-1:0] alu_op_ex,
   input  logic               mem_we_ex,
   input  logic               mem_re_ex,
   input  logic               mem_to_reg_ex,
   input  logic               wb_we,
   input  logic [RF_SIZE-1:0] wb_rd,
   input  logic [D_WIDTH-1:0] wb_data,
   output logic [D_WIDTH-1:0] alu_result_mem,
   output logic [D_WIDTH-1:0] store_data_mem,
   output logic [RF_SIZE-1:0] rd_mem,
   output logic               reg_write_mem,
   output logic               mem_we_mem,
   output logic               mem_re_mem,
   output logic               mem_to_reg_mem,
   output logic               illegal_mem
);

   logic [D_WIDTH-1:0] w_op_a;
   logic [D_WIDTH-1:0] w_op_b;
   logic [D_WIDTH-1:0] w_fwd_rs2;
   logic [D_WIDTH-1:0] w_alu_result;
   logic               w_illegal;
   ctrl_t              w_ctrl;

   logic [D_WIDTH-1:0] r_alu_result;
   logic [D_WIDTH-1:0] r_store_data;
   logic [RF_SIZE-1:0] r_rd;
   ctrl_t              r_ctrl;
   logic               r_illegal;

`ifdef EX_FWD_EN
   // Loads in EX/MEM are skipped: their data does not exist yet.
   function automatic logic [D_WIDTH-1:0] fwd_sel(input logic [RF_SIZE-1:0] src,
                                                  input logic [D_WIDTH-1:0] rf_val);
      logic [D_WIDTH-1:0] val;
      val = rf_val;
      if (src != '0) begin
         if (r_ctrl.reg_write && !r_ctrl.mem_to_reg && (r_rd == src))
            val = r_alu_result;
         else if (wb_we && (wb_rd == src))
            val = wb_data;
      end
      return val;
   endfunction

   always_comb begin
      w_op_a    = fwd_sel(rs1_ex, rs1_val_ex);
      w_fwd_rs2 = fwd_sel(rs2_ex, rs2_val_ex);
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{wb_we, wb_rd, wb_data, rs1_ex, rs2_ex};
   assign w_op_a       = rs1_val_ex;
   assign w_fwd_rs2    = rs2_val_ex;
`endif

   assign w_op_b = alu_src_imm_ex ? imm_ex : w_fwd_rs2;

   ex_stage_alu #(
      .D_WIDTH (D_WIDTH),
      .OP_SIZE (OP_SIZE)
   ) u_alu (
      .a       (w_op_a),
      .b       (w_op_b),
      .op      (alu_op_ex),
      .result  (w_alu_result),
      .illegal (w_illegal)
   );

   // An illegal instruction must not commit any architectural side effect.
   always_comb begin
      w_ctrl.reg_write  = reg_write_ex & ~w_illegal;
      w_ctrl.mem_we     = mem_we_ex & ~w_illegal;
      w_ctrl.mem_re     = mem_re_ex & ~w_illegal;
      w_ctrl.mem_to_reg = mem_to_reg_ex;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_result <= '0;
         r_store_data <= '0;
         r_rd         <= '0;
         r_ctrl       <= '0;
         r_illegal    <= 1'b0;
      end else if (flush) begin
         r_rd         <= '0;
         r_ctrl       <= '0;
         r_illegal    <= 1'b0;
      end else if (en) begin
         r_alu_result <= w_alu_result;
         r_store_data <= w_fwd_rs2;
         r_rd         <= rd_ex;
         r_ctrl       <= w_ctrl;
         r_illegal    <= w_illegal;
      end
   end

   assign alu_result_mem = r_alu_result;
   assign store_data_mem = r_store_data;
   assign rd_mem         = r_rd;
   assign reg_write_mem  = r_ctrl.reg_write;
   assign mem_we_mem     = r_ctrl.mem_we;
   assign mem_re_mem     = r_ctrl.mem_re;
   assign mem_to_reg_mem = r_ctrl.mem_to_reg;
   assign illegal_mem    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_stage                                                          |
// | Vector table plus hand sequences for ex_stage, queue scoreboard.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ex_stage;

`ifdef EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLT = 4'b0101;

   typedef struct {
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        rw, we, re, m2r, ill;
      logic        dc;
   } exp_t;

   typedef struct {
      string       name;
      logic [4:0]  rs1, rs2, rd, wb_rd;
      logic [31:0] v1, v2, imm, wb_data;
      logic        use_imm, rw, we, re, m2r, wb_we, en, flush;
      logic [3:0]  op;
      exp_t        exp;
   } vec_t;

   logic        clk, rst, en, flush;
   logic [4:0]  rs1_ex, rs2_ex, rd_ex, wb_rd, rd_mem;
   logic [31:0] rs1_val_ex, rs2_val_ex, imm_ex, wb_data;
   logic        reg_write_ex, alu_src_imm_ex, mem_we_ex, mem_re_ex, mem_to_reg_ex, wb_we;
   logic [3:0]  alu_op_ex;
   logic [31:0] alu_result_mem, store_data_mem;
   logic        reg_write_mem, mem_we_mem, mem_re_mem, mem_to_reg_mem, illegal_mem;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   vec_t tbl[15];

   ex_stage dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rs1_val_ex(rs1_val_ex), .rs2_val_ex(rs2_val_ex),
      .imm_ex(imm_ex), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
      .alu_src_imm_ex(alu_src_imm_ex), .alu_op_ex(alu_op_ex), .mem_we_ex(mem_we_ex),
      .mem_re_ex(mem_re_ex), .mem_to_reg_ex(mem_to_reg_ex),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem), .rd_mem(rd_mem),
      .reg_write_mem(reg_write_mem), .mem_we_mem(mem_we_mem), .mem_re_mem(mem_re_mem),
      .mem_to_reg_mem(mem_to_reg_mem), .illegal_mem(illegal_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(string nm, logic [4:0] rs1, logic [31:0] v1,
                               logic [4:0] rs2, logic [31:0] v2, logic use_imm,
                               logic [31:0] imm, logic [3:0] op, logic [4:0] rd,
                               logic rw, logic we, logic re, logic m2r, logic wbwe,
                               logic [4:0] wbrd, logic [31:0] wbd,
                               logic [31:0] ealu, logic [31:0] esd);
      vec_t v;
      v.name = nm; v.rs1 = rs1; v.v1 = v1; v.rs2 = rs2; v.v2 = v2;
      v.use_imm = use_imm; v.imm = imm; v.op = op; v.rd = rd;
      v.rw = rw; v.we = we; v.re = re; v.m2r = m2r;
      v.wb_we = wbwe; v.wb_rd = wbrd; v.wb_data = wbd;
      v.en = 1'b1; v.flush = 1'b0;
      v.exp.alu = ealu; v.exp.sd = esd; v.exp.rd = rd;
      v.exp.rw = rw; v.exp.we = we; v.exp.re = re; v.exp.m2r = m2r;
      v.exp.ill = 1'b0; v.exp.dc = 1'b0;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rs1_ex = v.rs1; rs2_ex = v.rs2; rs1_val_ex = v.v1; rs2_val_ex = v.v2;
      imm_ex = v.imm; rd_ex = v.rd; reg_write_ex = v.rw; alu_src_imm_ex = v.use_imm;
      alu_op_ex = v.op; mem_we_ex = v.we; mem_re_ex = v.re; mem_to_reg_ex = v.m2r;
      wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
      en = v.en; flush = v.flush;
   endtask

   task automatic check(input string nm);
      exp_t e;
      logic bad;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, no expected value", nm);
         return;
      end
      e = sb.pop_front();
      bad = (reg_write_mem !== e.rw) || (mem_we_mem !== e.we) || (mem_re_mem !== e.re) ||
            (mem_to_reg_mem !== e.m2r) || (illegal_mem !== e.ill);
      if (!e.dc)
         bad = bad || (alu_result_mem !== e.alu) || (store_data_mem !== e.sd) || (rd_mem !== e.rd);
      if (bad) begin
         n_bad++;
         $display("FAIL %s: got alu=%h sd=%h rd=%0d rw=%b we=%b re=%b m2r=%b ill=%b, want alu=%h sd=%h rd=%0d rw=%b we=%b re=%b m2r=%b ill=%b (data dc=%b)",
                  nm, alu_result_mem, store_data_mem, rd_mem, reg_write_mem, mem_we_mem,
                  mem_re_mem, mem_to_reg_mem, illegal_mem, e.alu, e.sd, e.rd, e.rw, e.we,
                  e.re, e.m2r, e.ill, e.dc);
      end
   endtask

   task automatic check_zero(input string nm);
      n_cmp++;
      if ({alu_result_mem, store_data_mem, rd_mem, reg_write_mem, mem_we_mem, mem_re_mem,
           mem_to_reg_mem, illegal_mem} !== '0) begin
         n_bad++;
         $display("FAIL %s: got alu=%h sd=%h rd=%0d rw=%b we=%b re=%b m2r=%b ill=%b, want all 0",
                  nm, alu_result_mem, store_data_mem, rd_mem, reg_write_mem, mem_we_mem,
                  mem_re_mem, mem_to_reg_mem, illegal_mem);
      end
   endtask

   task automatic step(input vec_t v);
      @(negedge clk);
      drive(v);
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
      check(v.name);
   endtask

   initial begin
      vec_t v;
      exp_t held;

      //          name        rs1 v1            rs2 v2            imm? imm  op      rd rw we re m2r wbwe wbrd wbd  exp_alu                          exp_sd
      tbl[0]  = mk("add_3_4",  2, 32'd3,        3, 32'd4,        0, 0,  OP_ADD, 1, 1, 0, 0, 0, 0, 0, 0,   32'd7,                           32'd4);
      tbl[1]  = mk("fwd_exmem",1, 32'd0,        4, 32'd2,        0, 0,  OP_SUB, 2, 1, 0, 0, 0, 1, 1, 99,  FWD ? 32'd5 : 32'hFFFF_FFFE,     32'd2);
      tbl[2]  = mk("x0_setup", 5, 32'hDEAD,     6, 32'd0,        0, 0,  OP_ADD, 0, 1, 0, 0, 0, 0, 0, 0,   32'hDEAD,                        32'd0);
      tbl[3]  = mk("x0_guard", 0, 32'd0,        7, 32'h10,       0, 0,  OP_ADD, 3, 1, 0, 0, 0, 1, 0, 32'h77, 32'h10,                       32'h10);
      tbl[4]  = mk("slt_neg",  8, 32'hFFFF_FFFF,9, 32'h33,       1, 1,  OP_SLT, 4, 1, 0, 0, 0, 0, 0, 0,   32'd1,                           32'h33);
      tbl[5]  = mk("slt_pos", 10, 32'd1,       11, 32'hFFFF_FFFF,0, 0,  OP_SLT, 5, 1, 0, 0, 0, 0, 0, 0,   32'd0,                           32'hFFFF_FFFF);
      tbl[6]  = mk("add_ovf", 12, 32'hFFFF_FFFF,13, 32'd1,       0, 0,  OP_ADD, 6, 1, 0, 0, 0, 0, 0, 0,   32'd0,                           32'd1);
      tbl[7]  = mk("and",     14, 32'hF0F0,    15, 32'hFF00,     0, 0,  OP_AND, 7, 1, 0, 0, 0, 0, 0, 0,   32'hF000,                        32'hFF00);
      tbl[8]  = mk("or",      14, 32'hF0F0,    15, 32'hFF00,     0, 0,  OP_OR,  8, 1, 0, 0, 0, 0, 0, 0,   32'hFFF0,                        32'hFF00);
      tbl[9]  = mk("xor",     14, 32'hF0F0,    15, 32'hFF00,     0, 0,  OP_XOR, 9, 1, 0, 0, 0, 0, 0, 0,   32'h0FF0,                        32'hFF00);
      tbl[10] = mk("store",   10, 32'd10,      20, 32'd0,        1, 8,  OP_ADD, 0, 0, 1, 0, 0, 1, 20, 32'h55, 32'd18,                      FWD ? 32'h55 : 32'd0);
      tbl[11] = mk("load",    16, 32'd100,     17, 32'd0,        1, 4,  OP_ADD, 11, 1, 0, 1, 1, 0, 0, 0,  32'd104,                         32'd0);
      tbl[12] = mk("no_ld_fwd",11, 32'd5,      18, 32'd6,        0, 0,  OP_ADD, 12, 1, 0, 0, 0, 0, 0, 0,  32'd11,                          32'd6);
      tbl[13] = mk("fwd_wb",  19, 32'd1,       21, 32'd2,        0, 0,  OP_ADD, 13, 1, 0, 0, 0, 1, 19, 40, FWD ? 32'd42 : 32'd3,           32'd2);
      tbl[14] = mk("fwd_rs2", 22, 32'd100,     13, 32'd0,        0, 0,  OP_SUB, 14, 1, 0, 0, 0, 0, 0, 0,  FWD ? 32'd58 : 32'd100,         FWD ? 32'd42 : 32'd0);

      rst = 1'b1;
      drive(mk("idle", 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;

      foreach (tbl[i]) step(tbl[i]);

      // Stall: new instruction presented, outputs must hold
      held = tbl[14].exp;
      for (int k = 0; k < 3; k++) begin
         v = mk("stall", 1, 32'd1, 2, 32'd1, 0, 0, OP_ADD, 15, 1, 1, 1, 0, 0, 0, 0, 0, 0);
         v.en = 1'b0;
         v.exp = held;
         step(v);
      end

      v = mk("flush_stall", 1, 32'd1, 2, 32'd1, 0, 0, OP_ADD, 15, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      v.en = 1'b0; v.flush = 1'b1;
      v.exp.rw = 0; v.exp.we = 0; v.exp.re = 0; v.exp.m2r = 0; v.exp.ill = 0; v.exp.dc = 1;
      step(v);

      v = mk("illegal_f", 24, 32'd5, 23, 32'd7, 0, 0, 4'b1111, 16, 1, 1, 1, 0, 0, 0, 0, 32'd0, 32'd7);
      v.exp.rw = 0; v.exp.we = 0; v.exp.re = 0; v.exp.ill = 1;
      step(v);

      v = mk("illegal_6", 24, 32'd5, 23, 32'd7, 0, 0, 4'b0110, 17, 1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd7);
      v.exp.rw = 0; v.exp.ill = 1;
      step(v);

      step(mk("after_ill", 17, 32'd3, 25, 32'd4, 0, 0, OP_ADD, 18, 1, 0, 0, 0, 0, 0, 0, 32'd7, 32'd4));

      // Asynchronous reset mid-cycle while enabled
      @(negedge clk);
      drive(mk("pre_rst", 1, 32'd9, 2, 32'd9, 0, 0, OP_ADD, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      #2 rst = 1'b1;
      #1 check_zero("rst_async");
      @(posedge clk);
      #1 check_zero("rst_hold");
      @(negedge clk);
      rst = 1'b0;
      step(mk("post_rst_add", 2, 32'd5, 3, 32'd7, 0, 0, OP_ADD, 1, 1, 0, 0, 0, 0, 0, 0, 32'd12, 32'd7));

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d leftover entries, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
